// File: rtl/uart_mem_loader.sv
// UART boot loader: assembles little-endian words from received bytes, writes them to RAM from
// address 0, then releases the CPU. Define UART_LOADER_CHECKSUM_EN to require an 8-bit sum trailer.
module uart_mem_loader #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 12,
   parameter int TIMEOUT_CYCLES = 5000000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  uart_re,
   input  logic [7:0]            uart_data_rx,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  loading,
   output logic                  done,
   output logic                  error,
   output logic                  cpu_reset
);

   localparam int BPW   = DATA_WIDTH / 8;
   localparam int BIW   = (BPW > 1) ? $clog2(BPW) : 1;
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {HDR0, HDR1, DATA, LAST_WR, CSUM, FINISH, LOCKED} state_t;

   state_t                state_q, state_d;
   logic                  re_prev;
   logic                  accept;
   logic [15:0]           count_q, count_d;
   logic [BIW-1:0]        byte_idx_q, byte_idx_d;
   logic [15:0]           word_idx_q, word_idx_d;
   logic [DATA_WIDTH-1:0] word_q, word_d, word_next;
   logic [CNT_W-1:0]      idle_q, idle_d;
   logic                  timeout;
   logic                  mem_we_d, error_d;
   logic [ADDR_WIDTH-1:0] mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_d;
`ifdef UART_LOADER_CHECKSUM_EN
   logic [7:0]            sum_q, sum_d;
`endif

   assign accept    = uart_re & ~re_prev;
   assign timeout   = (idle_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign loading   = (state_q == HDR1) || (state_q == DATA) || (state_q == LAST_WR) ||
                      (state_q == CSUM);
   assign done      = (state_q == FINISH);
   assign cpu_reset = !((state_q == FINISH) || (state_q == LOCKED));

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= HDR0;
         re_prev    <= 1'b0;
         count_q    <= '0;
         byte_idx_q <= '0;
         word_idx_q <= '0;
         word_q     <= '0;
         idle_q     <= '0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         error      <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
         sum_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         re_prev    <= uart_re;
         count_q    <= count_d;
         byte_idx_q <= byte_idx_d;
         word_idx_q <= word_idx_d;
         word_q     <= word_d;
         idle_q     <= idle_d;
         mem_we     <= mem_we_d;
         mem_addr   <= mem_addr_d;
         mem_wdata  <= mem_wdata_d;
         error      <= error_d;
`ifdef UART_LOADER_CHECKSUM_EN
         sum_q      <= sum_d;
`endif
      end
   end

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      byte_idx_d  = byte_idx_q;
      word_idx_d  = word_idx_q;
      word_d      = word_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
      error_d     = error;
`ifdef UART_LOADER_CHECKSUM_EN
      sum_d       = sum_q;
`endif
      word_next   = word_q;
      word_next[byte_idx_q*8 +: 8] = uart_data_rx;
      idle_d      = (accept || !loading) ? '0 : idle_q + CNT_W'(1);

      case (state_q)
         HDR0: if (accept) begin
            count_d = {8'h00, uart_data_rx};
            error_d = 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
            sum_d   = 8'h00;
`endif
            state_d = HDR1;
         end
         HDR1: if (accept) begin
            count_d[15:8] = uart_data_rx;
            byte_idx_d    = '0;
            word_idx_d    = '0;
            state_d       = ({uart_data_rx, count_q[7:0]} == 16'h0000) ? FINISH : DATA;
         end
         DATA: if (accept) begin
            word_d = word_next;
`ifdef UART_LOADER_CHECKSUM_EN
            sum_d  = sum_q + uart_data_rx;
`endif
            if (byte_idx_q == BIW'(BPW - 1)) begin
               mem_we_d    = 1'b1;
               mem_addr_d  = ADDR_WIDTH'(word_idx_q);
               mem_wdata_d = word_next;
               byte_idx_d  = '0;
               word_idx_d  = word_idx_q + 16'd1;
               if (word_idx_q == count_q - 16'd1) state_d = LAST_WR;
            end else begin
               byte_idx_d = byte_idx_q + BIW'(1);
            end
         end
         // One cycle to let the final write strobe out before finishing.
`ifdef UART_LOADER_CHECKSUM_EN
         LAST_WR: state_d = CSUM;
         CSUM: if (accept) begin
            if (uart_data_rx == sum_q) begin
               state_d = FINISH;
            end else begin
               error_d = 1'b1;
               state_d = HDR0;
            end
         end
`else
         LAST_WR: state_d = FINISH;
`endif
         FINISH:  state_d = LOCKED;
         LOCKED:  state_d = LOCKED;
         default: state_d = HDR0;
      endcase

      // An accept in the expiry cycle keeps the load alive.
      if (loading && !accept && timeout) begin
         error_d = 1'b1;
         state_d = HDR0;
      end
   end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Scoreboard bench for uart_mem_loader (ADDR_WIDTH=2 to exercise wrap, short timeout).
// Expected writes are queued as bytes are sent and popped when mem_we fires.
module tb_uart_mem_loader;

   localparam int AW = 2;
   localparam int DW = 32;
   localparam int TO = 64;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          uart_re = 1'b0;
   logic [7:0]    uart_data_rx = 8'h00;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          loading, done, error, cpu_reset;

   exp_t          exp_q[$];
   logic [DW-1:0] words_q[$];
   int            n_tests = 0;
   int            n_fail = 0;
   int            cyc = 0;
   int            acc_cyc = 0;
   int            last_we_cyc = 0;
   int            done_cyc = 0;
   int            we_cnt = 0;
   int            done_cnt = 0;
   logic          mon_re_prev = 1'b0;
   logic          prev_done = 1'b0;

   uart_mem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .uart_re(uart_re), .uart_data_rx(uart_data_rx),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .loading(loading), .done(done), .error(error), .cpu_reset(cpu_reset)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   // Inputs change 1 time unit after posedge, so the negedge view is stable.
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (mem_we) begin
         we_cnt++;
         last_we_cyc = cyc;
         check("we_latency", 64'(cyc - acc_cyc), 64'd1);
         if (exp_q.size() == 0) begin
            check("we_unexpected", 64'd1, 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("we_addr", 64'(mem_addr), 64'(e.addr));
            check("we_data", 64'(mem_wdata), 64'(e.data));
         end
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
         check("done_cpu_reset", 64'(cpu_reset), 64'd0);
         check("done_loading", 64'(loading), 64'd0);
         check("done_one_cycle", 64'(prev_done), 64'd0);
      end
      prev_done = done;
      if (uart_re && !mon_re_prev) acc_cyc = cyc;
      mon_re_prev = uart_re;
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 reset = 1'b1;
      uart_re = 1'b0;
      wait_cycles(3);
      reset = 1'b0;
      wait_cycles(1);
   endtask

   task automatic send_byte(input logic [7:0] b, input int hold);
      @(posedge clk);
      #1 uart_data_rx = b;
      uart_re = 1'b1;
      repeat (hold) @(posedge clk);
      #1 uart_re = 1'b0;
      wait_cycles(2);
   endtask

   // Places the accept exactly 'gap' cycles after the previous send_byte accept.
   task automatic send_gap(input logic [7:0] b, input int gap);
      repeat (gap - 5) @(posedge clk);
      send_byte(b, 2);
   endtask

   task automatic run_load(input int hold0);
      logic [15:0]   n;
      logic [7:0]    sum;
      logic [DW-1:0] w;
      exp_t          e;
      n   = 16'(words_q.size());
      sum = 8'h00;
      send_byte(n[7:0], hold0);
      send_byte(n[15:8], 2);
      for (int i = 0; i < words_q.size(); i++) begin
         w      = words_q[i];
         e.addr = AW'(i);
         e.data = w;
         exp_q.push_back(e);
         for (int b = 0; b < DW / 8; b++) begin
            sum = sum + w[8*b +: 8];
            send_byte(w[8*b +: 8], 2);
         end
      end
`ifdef UART_LOADER_CHECKSUM_EN
      send_byte(sum, 2);
`endif
      words_q.delete();
   endtask

   task automatic check_done_latency(input string tag);
`ifdef UART_LOADER_CHECKSUM_EN
      check(tag, 64'(done_cyc - acc_cyc), 64'd1);
`else
      check(tag, 64'(done_cyc - last_we_cyc), 64'd1);
`endif
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, w0;
      exp_t e;

      // Reset values
      wait_cycles(3);
      check("rst_mem_we", 64'(mem_we), 64'd0);
      check("rst_mem_addr", 64'(mem_addr), 64'd0);
      check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
      check("rst_loading", 64'(loading), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_error", 64'(error), 64'd0);
      check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
      reset = 1'b0;
      wait_cycles(2);

      // Two-word load
      d0 = done_cnt;
      words_q.push_back(32'h12345678);
      words_q.push_back(32'hDEADBEEF);
      run_load(2);
      wait_cycles(4);
      check("t1_done_cnt", 64'(done_cnt - d0), 64'd1);
      check_done_latency("t1_done_latency");
      check("t1_cpu_reset", 64'(cpu_reset), 64'd0);
      check("t1_loading", 64'(loading), 64'd0);
      check("t1_queue_empty", 64'(exp_q.size()), 64'd0);

      // Zero-word load
      do_reset();
      d0 = done_cnt;
      w0 = we_cnt;
      send_byte(8'h00, 2);
      send_byte(8'h00, 2);
`ifdef UART_LOADER_CHECKSUM_EN
      send_byte(8'h00, 2);
`endif
      wait_cycles(3);
      check("t2_done_cnt", 64'(done_cnt - d0), 64'd1);
      check("t2_done_latency", 64'(done_cyc - acc_cyc), 64'd1);
      check("t2_no_we", 64'(we_cnt - w0), 64'd0);
      check("t2_cpu_reset", 64'(cpu_reset), 64'd0);

      // Timeout mid-word, then retry with an accept exactly at the expiry cycle
      do_reset();
      d0 = done_cnt;
      w0 = we_cnt;
      send_byte(8'h01, 2);
      check("t3_loading", 64'(loading), 64'd1);
      send_byte(8'h00, 2);
      send_byte(8'hAA, 2);
      wait_cycles(20);
      check("t3_no_early_error", 64'(error), 64'd0);
      wait_cycles(TO);
      check("t3_error", 64'(error), 64'd1);
      check("t3_loading_low", 64'(loading), 64'd0);
      check("t3_cpu_reset", 64'(cpu_reset), 64'd1);
      check("t3_no_we", 64'(we_cnt - w0), 64'd0);
      check("t3_no_done", 64'(done_cnt - d0), 64'd0);
      send_byte(8'h01, 2);
      check("t3_error_cleared", 64'(error), 64'd0);
      send_byte(8'h00, 2);
      e.addr = '0;
      e.data = 32'h44332211;
      exp_q.push_back(e);
      send_byte(8'h11, 2);
      send_gap(8'h22, TO);
      check("t3_gap_no_error", 64'(error), 64'd0);
      send_byte(8'h33, 2);
      send_byte(8'h44, 2);
`ifdef UART_LOADER_CHECKSUM_EN
      send_byte(8'hAA, 2);
`endif
      wait_cycles(3);
      check("t3_retry_done", 64'(done_cnt - d0), 64'd1);
      check("t3_retry_error", 64'(error), 64'd0);
      check("t3_retry_cpu_reset", 64'(cpu_reset), 64'd0);

      // Long uart_re level on the first header byte, five words wrap the 2-bit address, then LOCKED
      do_reset();
      d0 = done_cnt;
      words_q.push_back(32'hA0A1A2A3);
      words_q.push_back(32'hB0B1B2B3);
      words_q.push_back(32'hC0C1C2C3);
      words_q.push_back(32'hD0D1D2D3);
      words_q.push_back(32'hE0E1E2E3);
      run_load(10);
      wait_cycles(3);
      check("t4_done_cnt", 64'(done_cnt - d0), 64'd1);
      check("t4_queue_empty", 64'(exp_q.size()), 64'd0);
      w0 = we_cnt;
      d0 = done_cnt;
      for (int i = 0; i < 6; i++) send_byte(8'h00 + 8'(i), 2);
      wait_cycles(3);
      check("t4_locked_no_we", 64'(we_cnt - w0), 64'd0);
      check("t4_locked_no_done", 64'(done_cnt - d0), 64'd0);
      check("t4_locked_cpu_reset", 64'(cpu_reset), 64'd0);

      // Reset mid-load returns to reset values; a fresh load then starts at address 0
      do_reset();
      send_byte(8'h01, 2);
      send_byte(8'h00, 2);
      send_byte(8'h11, 2);
      do_reset();
      check("t5_loading", 64'(loading), 64'd0);
      check("t5_cpu_reset", 64'(cpu_reset), 64'd1);
      d0 = done_cnt;
      words_q.push_back(32'h0BADF00D);
      run_load(2);
      wait_cycles(3);
      check("t5_done_cnt", 64'(done_cnt - d0), 64'd1);

`ifdef UART_LOADER_CHECKSUM_EN
      // Checksum match and mismatch
      do_reset();
      d0 = done_cnt;
      words_q.push_back(32'h04030201);
      run_load(2);
      wait_cycles(3);
      check("cs_ok_done", 64'(done_cnt - d0), 64'd1);
      check("cs_ok_error", 64'(error), 64'd0);
      do_reset();
      d0 = done_cnt;
      e.addr = '0;
      e.data = 32'h04030201;
      exp_q.push_back(e);
      send_byte(8'h01, 2);
      send_byte(8'h00, 2);
      for (int i = 1; i <= 4; i++) send_byte(8'(i), 2);
      send_byte(8'h0B, 2);
      wait_cycles(3);
      check("cs_bad_error", 64'(error), 64'd1);
      check("cs_bad_no_done", 64'(done_cnt - d0), 64'd0);
      check("cs_bad_cpu_reset", 64'(cpu_reset), 64'd1);
`endif

      wait_cycles(2);
      check("final_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_mem_loader.md
Name: uart_mem_loader

Overview:
- Consumes received bytes from the UART receiver (uart_re / uart_data_rx) and assembles them into little-endian memory words.
- Writes those words sequentially into program/data RAM from address 0, then releases the CPU from reset.
- Sits between the UART receiver and the CPU instruction memory write port; acts as the boot loader.

Parameters:
- DATA_WIDTH, 32, memory word width; must be a multiple of 8.
- ADDR_WIDTH, 12, memory word-address width.
- TIMEOUT_CYCLES, 5000000, maximum idle clk cycles allowed between bytes once a load has started.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- uart_re  in  1  receiver byte-valid level; a new byte is signalled by its rising edge
- uart_data_rx  in  8  received byte; valid from the uart_re rising edge onward
- mem_we  out  1  memory write strobe, one cycle per word
- mem_addr  out  ADDR_WIDTH  word address
- mem_wdata  out  DATA_WIDTH  word data
- loading  out  1  high while a load is in progress (after the first header byte)
- done  out  1  one-cycle pulse when a load completes successfully
- error  out  1  sticky; cleared when the next load starts (first header byte)
- cpu_reset  out  1  holds the CPU in reset; high until done

Behaviour:
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, loading=0, done=0, error=0, cpu_reset=1, state=HDR0, re_prev=0.
- Byte accept:
  - re_prev is a register of uart_re.
  - accept = uart_re & ~re_prev; the byte is sampled from uart_data_rx in that same cycle.
  - Bytes arriving in any other cycle are ignored.
- Protocol: count_lo, count_hi (N, 16-bit little-endian word count), then N*BPW data bytes, where BPW = DATA_WIDTH/8. The first data byte is the LSB of each word.
- States:
  - HDR0: on accept, store count_lo, set loading=1, clear error, go to HDR1.
  - HDR1: on accept, store count_hi. If N==0, go to FINISH; otherwise go to DATA with byte_idx=0, word_idx=0.
  - DATA: on accept, shift the byte into the word register at lane byte_idx.
    - When byte_idx==BPW-1, in the next cycle drive mem_we=1 for one cycle, with mem_addr=word_idx[ADDR_WIDTH-1:0] and mem_wdata=the assembled word. Then clear byte_idx and increment word_idx.
    - After the write of word N-1, go to FINISH (or CSUM when CHECKSUM_EN is defined).
  - FINISH: for one cycle assert done=1, drive cpu_reset=0, drive loading=0, then go to LOCKED.
  - LOCKED: ignore all bytes; cpu_reset stays 0; only reset exits this state.
- Latency: mem_we is high exactly 1 cycle after the accept of the last byte of a word. done is high 1 cycle after the last write (or after the checksum accept).
- Address wrap: when N > 2^ADDR_WIDTH, mem_addr wraps modulo 2^ADDR_WIDTH. The wrap is not an error.
- Timeout:
  - The idle counter resets on every accept.
  - In HDR1, DATA or CSUM, if it reaches TIMEOUT_CYCLES: error=1, loading=0, go to HDR0. Partially assembled words are discarded; cpu_reset stays 1 (retry allowed).
  - In HDR0 there is no timeout.
- Simultaneous events: an accept in the same cycle as the timeout expiry counts as the accept (no error).
- Reset mid-load: returns to the reset values immediately. Words already written to memory are not undone.

Optional Feature:
- Macro: UART_LOADER_CHECKSUM_EN.
- Defined:
  - After the last data word, the CSUM state waits for one extra byte.
  - Expected value = 8-bit sum, modulo 256, of all data bytes (the header is excluded).
  - Match: go to FINISH.
  - Mismatch: error=1, loading=0, return to HDR0, cpu_reset stays 1.
  - The timeout also applies in CSUM.
- Undefined: there is no CSUM state; the DATA state goes directly to FINISH.

Test Plan:
- Bytes 02 00 | 78 56 34 12 | EF BE AD DE -> mem_we pulses twice: addr0=0x12345678, addr1=0xDEADBEEF; one-cycle done; cpu_reset falls with done; loading falls.
- Bytes 00 00 -> no mem_we; done pulses 1 cycle after the count_hi accept; cpu_reset=0.
- Bytes 01 00 AA, then silence for TIMEOUT_CYCLES -> error=1, no mem_we, cpu_reset=1. A subsequent full valid load clears error and completes.
- uart_re held high for 10 cycles with one byte 05 -> only one accept (state goes to HDR1 only). After done, further bytes produce no mem_we (LOCKED).
- With ADDR_WIDTH=2 and N=5 -> the 5th word is written at addr 0.
- With UART_LOADER_CHECKSUM_EN: 01 00 01 02 03 04 0A -> write 0x04030201 plus done. With trailer 0B instead -> error=1, no done, cpu_reset=1.
